// File: rtl/dma_channel_arbiter_pkg.sv
// Shared types for the DMA channel arbiter: FSM states, channel encoding and
// one-hot helper.
package dma_channel_arbiter_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_GRANT,
        ARB_RELEASE
    } ARB_STATE_e;

    typedef enum logic [1:0] {
        CH0,
        CH1,
        CH2,
        CH3
    } CHANNEL_SELECT_e;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] ch);
        return NUM_CH'(1) << ch;
    endfunction

endpackage

// File: rtl/dma_channel_arbiter_if.sv
// Request, hold-handshake and grant signals between the arbiter and its
// environment (command/mask registers, CPU hold logic, timing FSM).
interface dma_channel_arbiter_if;
    import dma_channel_arbiter_pkg::*;

    logic [NUM_CH-1:0] DREQ;
    logic              DREQ_SENSE_LOW;
    logic              DACK_SENSE_HIGH;
    logic              ROTATE_PRIORITY;
    logic              CTRL_DISABLE;
    logic [NUM_CH-1:0] MASK;
    logic [NUM_CH-1:0] SW_REQ;
    logic              HLDA;
    logic              EOS;
    logic              HRQ;
    logic [NUM_CH-1:0] DACK;
    logic              GRANT_VALID;
    CHANNEL_SELECT_e   GRANT_CH;

    modport master (
        input  DREQ, DREQ_SENSE_LOW, DACK_SENSE_HIGH, ROTATE_PRIORITY,
               CTRL_DISABLE, MASK, SW_REQ, HLDA, EOS,
        output HRQ, DACK, GRANT_VALID, GRANT_CH
    );

    modport slave (
        output DREQ, DREQ_SENSE_LOW, DACK_SENSE_HIGH, ROTATE_PRIORITY,
               CTRL_DISABLE, MASK, SW_REQ, HLDA, EOS,
        input  HRQ, DACK, GRANT_VALID, GRANT_CH
    );

endinterface

// File: rtl/dma_channel_arbiter_prio_enc.sv
// Combinational priority pick: rotate so the pointer channel sits at bit 0,
// take the lowest set bit, then rotate the index back.
module dma_priority_encoder
    import dma_channel_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        pointer,
    output logic [1:0]        winner,
    output logic              any
);

    logic [NUM_CH-1:0] req_rot;
    logic [1:0]        pick;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
            assign req_rot[gi] = req[2'(gi) + pointer];
        end
    endgenerate

    always_comb begin
        pick = 2'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) pick = 2'(i);
        end
        winner = pick + pointer;
        any    = |req;
    end

endmodule

// File: rtl/dma_channel_arbiter.sv
// Conditions DREQ, runs the HRQ/HLDA handshake and holds a one-hot grant
// (driving DACK) for the chosen channel until end of service.
module dma_channel_arbiter
    import dma_channel_arbiter_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RESET_N,
    dma_channel_arbiter_if.master  bus
);

    ARB_STATE_e        state_q, state_d;
    logic [NUM_CH-1:0] dreq_q;
    logic [NUM_CH-1:0] grant_q, grant_d;
    CHANNEL_SELECT_e   grant_ch_q, grant_ch_d;
    logic              hrq_q, hrq_d;
    logic              grant_valid_q, grant_valid_d;
    logic [1:0]        ptr_q, ptr_d;

    logic [NUM_CH-1:0] req;
    logic [1:0]        winner;
    logic              any_req;

    // SW_REQ bypasses both the sense inversion and the mask.
    assign req = ((dreq_q ^ {NUM_CH{bus.DREQ_SENSE_LOW}}) & ~bus.MASK) | bus.SW_REQ;

    dma_priority_encoder u_prio (
        .req     (req),
        .pointer (ptr_q),
        .winner  (winner),
        .any     (any_req)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_ch_d    = grant_ch_q;
        hrq_d         = hrq_q;
        grant_valid_d = grant_valid_q;
        ptr_d         = ptr_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (any_req && !bus.CTRL_DISABLE) begin
                    state_d = ARB_REQ;
                    hrq_d   = 1'b1;
                end
            end
            ARB_REQ: begin
                if (bus.CTRL_DISABLE) begin
                    state_d = ARB_RELEASE;
                    hrq_d   = 1'b0;
                end else if (bus.HLDA) begin
                    if (any_req) begin
                        state_d       = ARB_GRANT;
                        grant_d       = ch_onehot(winner);
                        grant_ch_d    = CHANNEL_SELECT_e'(winner);
                        grant_valid_d = 1'b1;
                    end else begin
                        state_d = ARB_RELEASE;
                        hrq_d   = 1'b0;
                    end
                end
            end
            ARB_GRANT: begin
                // EOS wins over a simultaneous HLDA drop so the pointer still rotates.
                if (bus.EOS) begin
                    state_d       = ARB_RELEASE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    hrq_d         = 1'b0;
                    ptr_d         = grant_ch_q + 2'd1;
                end else if (!bus.HLDA) begin
                    state_d       = ARB_IDLE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    hrq_d         = 1'b0;
                end
            end
            ARB_RELEASE: begin
                hrq_d = 1'b0;
                if (!bus.HLDA) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase

        if (!bus.ROTATE_PRIORITY) ptr_d = 2'd0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= ARB_IDLE;
            dreq_q        <= '0;
            grant_q       <= '0;
            grant_ch_q    <= CH0;
            hrq_q         <= 1'b0;
            grant_valid_q <= 1'b0;
            ptr_q         <= 2'd0;
        end else begin
            state_q       <= state_d;
            dreq_q        <= bus.DREQ;
            grant_q       <= grant_d;
            grant_ch_q    <= grant_ch_d;
            hrq_q         <= hrq_d;
            grant_valid_q <= grant_valid_d;
            ptr_q         <= ptr_d;
        end
    end

    assign bus.HRQ         = hrq_q;
    assign bus.GRANT_VALID = grant_valid_q;
    assign bus.GRANT_CH    = grant_ch_q;
    assign bus.DACK        = grant_q ^ {NUM_CH{~bus.DACK_SENSE_HIGH}};

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Scoreboard bench for dma_channel_arbiter: stimulus pushes expected grants,
// a monitor pops and checks them on each GRANT_VALID rising.
module tb_dma_channel_arbiter;
    import dma_channel_arbiter_pkg::*;

    logic CLK;
    logic RESET_N;

    dma_channel_arbiter_if bus ();

    dma_channel_arbiter dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] ch;
        logic [3:0] dack;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_gv_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic wait_hrq(input string name);
        for (int i = 0; i < 20 && bus.HRQ !== 1'b1; i++) tick();
        chk({name, "_hrq_rise"}, 32'(bus.HRQ), 32'd1);
    endtask

    // Full service: request, grant, EOS, HLDA drop. New DREQ/SW_REQ applied with EOS.
    task automatic do_service(input string name, input logic [1:0] ch, input logic [3:0] dack_exp,
                              input logic [3:0] dreq_after, input logic [3:0] sw_after);
        wait_hrq(name);
        tick();
        tick();
        sb.push_back('{ch: ch, dack: dack_exp});
        bus.HLDA = 1'b1;
        tick();
        chk({name, "_hrq_held"}, 32'(bus.HRQ), 32'd1);
        chk({name, "_gv"}, 32'(bus.GRANT_VALID), 32'd1);
        bus.DREQ   = dreq_after;
        bus.SW_REQ = sw_after;
        bus.EOS    = 1'b1;
        tick();
        bus.EOS  = 1'b0;
        bus.HLDA = 1'b0;
        chk({name, "_eos_hrq"}, 32'(bus.HRQ), 32'd0);
        chk({name, "_eos_gv"}, 32'(bus.GRANT_VALID), 32'd0);
        chk({name, "_eos_dack"}, 32'(bus.DACK), 32'hF);
        tick();
    endtask

    // Monitor: one expected entry per grant presented by the DUT.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (bus.GRANT_VALID === 1'b1 && mon_gv_prev !== 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_grant: got GRANT_CH=%0d DACK=%b required no grant",
                             bus.GRANT_CH, bus.DACK);
                end else begin
                    e = sb.pop_front();
                    $display("grant ch=%0d dack=%b (expected ch=%0d dack=%b)",
                             bus.GRANT_CH, bus.DACK, e.ch, e.dack);
                    chk("mon_grant_ch", 32'(bus.GRANT_CH), 32'(e.ch));
                    chk("mon_dack", 32'(bus.DACK), 32'(e.dack));
                end
            end
            mon_gv_prev = bus.GRANT_VALID;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET_N             = 1'b0;
        bus.DREQ            = '0;
        bus.DREQ_SENSE_LOW  = 1'b0;
        bus.DACK_SENSE_HIGH = 1'b0;
        bus.ROTATE_PRIORITY = 1'b0;
        bus.CTRL_DISABLE    = 1'b0;
        bus.MASK            = '0;
        bus.SW_REQ          = '0;
        bus.HLDA            = 1'b0;
        bus.EOS             = 1'b0;
        tick();
        tick();
        chk("rst_dack", 32'(bus.DACK), 32'hF);
        chk("rst_hrq", 32'(bus.HRQ), 32'd0);
        chk("rst_gv", 32'(bus.GRANT_VALID), 32'd0);
        chk("rst_grant_ch", 32'(bus.GRANT_CH), 32'd0);
        RESET_N = 1'b1;
        tick();

        // Fixed priority: ch1 beats ch3, then ch3 after ch1 drops.
        bus.DREQ = 4'b1010;
        tick();
        chk("fix_hrq_latency_1", 32'(bus.HRQ), 32'd0);
        tick();
        chk("fix_hrq_latency_2", 32'(bus.HRQ), 32'd1);
        do_service("fix_a", 2'd1, 4'b1101, 4'b1000, 4'b0000);
        do_service("fix_b", 2'd3, 4'b0111, 4'b0000, 4'b0000);

        // Rotating priority with all four requests held.
        bus.ROTATE_PRIORITY = 1'b1;
        bus.DREQ = 4'b1111;
        do_service("rot0", 2'd0, 4'b1110, 4'b1111, 4'b0000);
        do_service("rot1", 2'd1, 4'b1101, 4'b1111, 4'b0000);
        do_service("rot2", 2'd2, 4'b1011, 4'b1111, 4'b0000);
        do_service("rot3", 2'd3, 4'b0111, 4'b1111, 4'b0000);
        do_service("rot4", 2'd0, 4'b1110, 4'b0000, 4'b0000);
        bus.ROTATE_PRIORITY = 1'b0;

        // Active-low DREQ sense with ch0 masked: nothing requests until SW_REQ.
        bus.MASK = 4'b1111;
        bus.DREQ = 4'b1110;
        tick();
        tick();
        bus.DREQ_SENSE_LOW = 1'b1;
        bus.MASK = 4'b0001;
        repeat (4) tick();
        chk("sense_masked_hrq", 32'(bus.HRQ), 32'd0);
        bus.SW_REQ = 4'b0001;
        tick();
        chk("sw_hrq_latency", 32'(bus.HRQ), 32'd1);
        do_service("sw", 2'd0, 4'b1110, 4'b1110, 4'b0000);
        bus.MASK = 4'b1111;
        tick();
        bus.DREQ = 4'b0000;
        bus.DREQ_SENSE_LOW = 1'b0;
        tick();
        tick();
        bus.MASK = 4'b0000;

        // DREQ2 pulse withdrawn before HLDA: release without any grant.
        bus.DREQ = 4'b0100;
        tick();
        bus.DREQ = 4'b0000;
        wait_hrq("withdraw");
        bus.HLDA = 1'b1;
        tick();
        chk("withdraw_hrq", 32'(bus.HRQ), 32'd0);
        chk("withdraw_dack", 32'(bus.DACK), 32'hF);
        chk("withdraw_gv", 32'(bus.GRANT_VALID), 32'd0);
        bus.HLDA = 1'b0;
        tick();
        tick();
        chk("withdraw_idle_hrq", 32'(bus.HRQ), 32'd0);

        // Bus lost during grant keeps the pointer; EOS with HLDA fall rotates it.
        bus.ROTATE_PRIORITY = 1'b1;
        bus.DREQ = 4'b0011;
        wait_hrq("lost");
        sb.push_back('{ch: 2'd0, dack: 4'b1110});
        bus.HLDA = 1'b1;
        tick();
        chk("lost_gv", 32'(bus.GRANT_VALID), 32'd1);
        bus.HLDA = 1'b0;
        tick();
        chk("lost_dack", 32'(bus.DACK), 32'hF);
        chk("lost_gv_clear", 32'(bus.GRANT_VALID), 32'd0);
        wait_hrq("lost_retry");
        sb.push_back('{ch: 2'd0, dack: 4'b1110});
        bus.HLDA = 1'b1;
        tick();
        bus.EOS  = 1'b1;
        bus.HLDA = 1'b0;
        tick();
        bus.EOS = 1'b0;
        chk("eos_hlda_hrq", 32'(bus.HRQ), 32'd0);
        chk("eos_hlda_gv", 32'(bus.GRANT_VALID), 32'd0);
        do_service("after_rotate", 2'd1, 4'b1101, 4'b0000, 4'b0000);
        bus.ROTATE_PRIORITY = 1'b0;

        // Asynchronous reset in the middle of a grant.
        bus.DREQ = 4'b0001;
        wait_hrq("arst");
        sb.push_back('{ch: 2'd0, dack: 4'b1110});
        bus.HLDA = 1'b1;
        tick();
        chk("arst_gv_before", 32'(bus.GRANT_VALID), 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        chk("arst_dack", 32'(bus.DACK), 32'hF);
        chk("arst_hrq", 32'(bus.HRQ), 32'd0);
        chk("arst_gv", 32'(bus.GRANT_VALID), 32'd0);
        bus.DREQ = 4'b0000;
        bus.HLDA = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();
        tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
